mem_port_arbiter: RTL

//  Shares one single-port main memory between instruction fetch (IF) and the memory stage (D: loads/stores).

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_rr_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF / data-stage memory port arbiter.
// Used by mem_arb_rr_pick and mem_port_arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam int MAX_MEM_LAT = 7;
    localparam int CNT_W       = $clog2(MAX_MEM_LAT + 1);

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way round-robin picker.
// A lone requester always wins; on a tie the one that did not win last wins.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_win,
    output logic [1:0] grant,
    output logic       win
);

    always_comb begin
        win   = REQ_IF;
        grant = 2'b00;
        unique case (1'b1)
            (req[1] & req[0]):  win = ~last_win;
            (req[1] & ~req[0]): win = REQ_D;
            (req[0] & ~req[1]): win = REQ_IF;
            default:            win = REQ_IF;
        endcase
        if (|req) begin
            grant = (win == REQ_D) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the memory stage.
// Optional perf counters are built only when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [31:0]   perf_conflict,
    output logic [31:0]   perf_wait
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    arb_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             owner, owner_nxt;
    logic             last_win, last_win_nxt;

    logic       grant_ok;
    logic [1:0] req_v;
    logic [1:0] grant;
    logic       win;
    logic       rd_gnt;
    logic       wr_gnt;
    logic       rsp;

    // Reset also gates grants so every output reads 0 while rst is low.
    assign grant_ok = rst & ((state == ARB_IDLE) | (cnt == '0));
    assign req_v    = {d_req, if_req} & {2{grant_ok}};

    mem_arb_rr_pick u_pick (
        .req      (req_v),
        .last_win (last_win),
        .grant    (grant),
        .win      (win)
    );

    assign if_gnt = grant[0];
    assign d_gnt  = grant[1];
    assign wr_gnt = grant[1] & d_we;
    assign rd_gnt = (|grant) & ~wr_gnt;
    assign rsp    = (state == ARB_BUSY) & (cnt == '0);

    assign mem_re    = rd_gnt;
    assign mem_we    = wr_gnt;
    assign mem_addr  = grant[1] ? d_addr : (grant[0] ? if_addr : '0);
    assign mem_wdata = wr_gnt ? d_wdata : '0;

    assign if_rvalid = rsp & (owner == REQ_IF);
    assign d_rvalid  = rsp & (owner == REQ_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign busy      = (state == ARB_BUSY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            cnt      <= '0;
            owner    <= REQ_IF;
            last_win <= REQ_IF;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            owner    <= owner_nxt;
            last_win <= last_win_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        owner_nxt    = owner;
        last_win_nxt = last_win;
        if (&req_v) begin
            last_win_nxt = win;
        end
        if (rd_gnt) begin
            state_nxt = ARB_BUSY;
            cnt_nxt   = LAT_M1;
            owner_nxt = win;
        end else if (state == ARB_BUSY) begin
            if (cnt == '0) begin
                state_nxt = ARB_IDLE;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] conf_q;
    logic [31:0] wait_q;
    logic        wait_ev;

    assign wait_ev = (if_req & ~if_gnt) | (d_req & ~d_gnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conf_q <= '0;
            wait_q <= '0;
        end else begin
            if ((&req_v) && (conf_q != '1)) begin
                conf_q <= conf_q + 32'd1;
            end
            if (wait_ev && (wait_q != '1)) begin
                wait_q <= wait_q + 32'd1;
            end
        end
    end

    assign perf_conflict = conf_q;
    assign perf_wait     = wait_q;
`else
    assign perf_conflict = 32'h0;
    assign perf_wait     = 32'h0;
`endif

endmodule
